// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI slave model of an ADC128S-style A2D converter.
// Decodes a 16-bit command frame (channel in bits [13:11]) and, in the
// following frame, shifts back the 12-bit value of the commanded channel.
module a2d_spi_resp #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] UNUSED_VAL  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] lft_ld_val,
    input  logic [11:0] rght_ld_val,
    input  logic [11:0] batt_val,
    output logic        cmd_vld,
    output logic [2:0]  last_chnl,
    output logic        frm_err
);

    typedef enum logic [1:0] {
        WAIT_HI,
        IDLE,
        SHIFT
    } state_t;

    state_t state, nxt_state;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_hist, sclk_hist;
    logic [SYNC_STAGES:0]   warm;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [4:0]  bit_cnt;
    logic [15:0] tx_shift, rx_shift;
    logic [11:0] resp;

    logic load, do_rx, do_tx, vld_set, err_set;

    // Synchronizers plus one history flop per signal for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_hist   <= 1'b1;
            sclk_hist <= 1'b1;
            warm      <= '0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_hist   <= ss_sync[SYNC_STAGES-1];
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_hist & ~ss_s;
    assign ss_rise   = ~ss_hist & ss_s;
    assign sclk_rise = ~sclk_hist & sclk_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_HI;
        else     state <= nxt_state;
    end

    // Next-state logic; WAIT_HI also waits for the synchronizer reset
    // values to drain so a frame cut by reset cannot be re-entered.
    always_comb begin
        nxt_state = state;
        unique case (state)
            WAIT_HI: if (warm[SYNC_STAGES] && ss_s) nxt_state = IDLE;
            IDLE:    if (ss_fall) nxt_state = SHIFT;
            SHIFT:   if (ss_rise) nxt_state = IDLE;
            default: nxt_state = WAIT_HI;
        endcase
    end

    // Datapath controls; an SS_n edge masks any SCLK edge in the same clk
    always_comb begin
        load    = 1'b0;
        do_rx   = 1'b0;
        do_tx   = 1'b0;
        vld_set = 1'b0;
        err_set = 1'b0;
        unique case (state)
            IDLE: load = ss_fall;
            SHIFT: begin
                if (ss_rise) begin
                    vld_set = (bit_cnt == 5'd16);
                    err_set = (bit_cnt != 5'd16);
                end else begin
                    do_rx = sclk_rise;
                    do_tx = sclk_fall && (bit_cnt != 5'd0) && (bit_cnt <= 5'd15);
                end
            end
            default: ;
        endcase
    end

    // Response mux, consumed only on the load cycle
    always_comb begin
        case (last_chnl)
            3'd0:    resp = lft_ld_val;
            3'd4:    resp = rght_ld_val;
            3'd5:    resp = batt_val;
            default: resp = UNUSED_VAL;
        endcase
    end

    // Shift registers, bit counter, channel latch and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            last_chnl <= 3'd0;
            cmd_vld   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            cmd_vld <= vld_set;
            frm_err <= err_set;
            if (load) begin
                bit_cnt  <= '0;
                tx_shift <= {4'h0, resp};
            end
            if (do_rx) begin
                rx_shift <= {rx_shift[14:0], mosi_s};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (do_tx) tx_shift <= {tx_shift[14:0], 1'b0};
            if (vld_set) last_chnl <= rx_shift[13:11];
        end
    end

    // MISO is a gate of two flops only
    always_comb begin
        MISO = (state == SHIFT) & tx_shift[15];
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: two instances (default UNUSED_VAL and 12'h5A5)
// share one SPI bus; expected frame results are queued and checked at
// frame end.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI;
    logic        MISO, MISO2;
    logic        cmd_vld, cmd_vld2, frm_err, frm_err2;
    logic [2:0]  last_chnl, last_chnl2;
    logic [11:0] lft, rght, batt;

    always #5 clk = ~clk;

    a2d_spi_resp dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .lft_ld_val(lft), .rght_ld_val(rght), .batt_val(batt),
        .cmd_vld(cmd_vld), .last_chnl(last_chnl), .frm_err(frm_err)
    );

    a2d_spi_resp #(.SYNC_STAGES(3), .UNUSED_VAL(12'h5A5)) dut2 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO2),
        .lft_ld_val(lft), .rght_ld_val(rght), .batt_val(batt),
        .cmd_vld(cmd_vld2), .last_chnl(last_chnl2), .frm_err(frm_err2)
    );

    typedef struct {
        logic [15:0] cmd;
        int          nbits;
        logic [11:0] lft, rght, batt;
        logic [15:0] exp_miso, exp_miso2;
        int          exp_vld, exp_err;
        logic [2:0]  exp_chnl;
    } vec_t;

    typedef struct {
        logic [15:0] miso, miso2;
        int          vld, err;
        logic [2:0]  chnl;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    int n_vld = 0, n_err = 0, n_vld2 = 0, n_err2 = 0;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_vld  === 1'b1) n_vld++;
        if (frm_err  === 1'b1) n_err++;
        if (cmd_vld2 === 1'b1) n_vld2++;
        if (frm_err2 === 1'b1) n_err2++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] cmd, input int nbits, input int rst_bit,
                             input int chg_bit, input logic [11:0] chg_val,
                             output logic [15:0] cap, output logic [15:0] cap2);
        cap  = '0;
        cap2 = '0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = cmd[15];
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            repeat (8) @(negedge clk);
            cap[15-i]  = MISO;
            cap2[15-i] = MISO2;
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
            if (i == chg_bit) batt = chg_val;
            if (i + 1 == rst_bit) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_frame(input string name, input logic [15:0] cmd, input int nbits,
                            input int rst_bit, input int chg_bit, input logic [11:0] chg_val,
                            input logic [15:0] e_miso, input logic [15:0] e_miso2,
                            input int e_vld, input int e_err, input logic [2:0] e_chnl);
        exp_t        e;
        exp_t        got;
        logic [15:0] cap, cap2;
        int          v0, r0, v20, r20;
        e.miso  = e_miso;
        e.miso2 = e_miso2;
        e.vld   = e_vld;
        e.err   = e_err;
        e.chnl  = e_chnl;
        sb.push_back(e);
        v0 = n_vld; r0 = n_err; v20 = n_vld2; r20 = n_err2;
        run_frame(cmd, nbits, rst_bit, chg_bit, chg_val, cap, cap2);
        if (sb.size() == 0) begin
            check({name, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({name, " miso"},       {16'h0, cap},           {16'h0, got.miso});
            check({name, " miso_u5a5"},  {16'h0, cap2},          {16'h0, got.miso2});
            check({name, " cmd_vld"},    32'(n_vld - v0),        32'(got.vld));
            check({name, " frm_err"},    32'(n_err - r0),        32'(got.err));
            check({name, " cmd_vld2"},   32'(n_vld2 - v20),      32'(got.vld));
            check({name, " frm_err2"},   32'(n_err2 - r20),      32'(got.err));
            check({name, " last_chnl"},  {29'h0, last_chnl},     {29'h0, got.chnl});
            check({name, " last_chnl2"}, {29'h0, last_chnl2},    {29'h0, got.chnl});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           cmd      n   lft      rght     batt     miso      miso2     v  e  chnl
        vecs[0] = '{16'h2000, 16, 12'hABC, 12'h000, 12'h000, 16'h0ABC, 16'h0ABC, 1, 0, 3'd4};
        vecs[1] = '{16'h2800, 16, 12'hABC, 12'h123, 12'h000, 16'h0123, 16'h0123, 1, 0, 3'd5};
        vecs[2] = '{16'h2800, 16, 12'hABC, 12'h123, 12'hD80, 16'h0D80, 16'h0D80, 1, 0, 3'd5};
        vecs[3] = '{16'h1800, 12, 12'hABC, 12'h123, 12'hD80, 16'h0D80, 16'h0D80, 0, 1, 3'd5};
        vecs[4] = '{16'h0800, 16, 12'hABC, 12'h123, 12'hD80, 16'h0D80, 16'h0D80, 1, 0, 3'd1};
        vecs[5] = '{16'h0000, 16, 12'hABC, 12'h123, 12'hD80, 16'h0000, 16'h05A5, 1, 0, 3'd0};
        vecs[6] = '{16'h2800, 16, 12'hABC, 12'h123, 12'hD80, 16'h0ABC, 16'h0ABC, 1, 0, 3'd5};

        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        lft  = '0;
        rght = '0;
        batt = '0;
        repeat (5) @(negedge clk);
        check("reset MISO",      {31'h0, MISO},      32'd0);
        check("reset cmd_vld",   {31'h0, cmd_vld},   32'd0);
        check("reset frm_err",   {31'h0, frm_err},   32'd0);
        check("reset last_chnl", {29'h0, last_chnl}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            lft  = vecs[k].lft;
            rght = vecs[k].rght;
            batt = vecs[k].batt;
            do_frame($sformatf("vec%0d", k), vecs[k].cmd, vecs[k].nbits, -1, -1, 12'h000,
                     vecs[k].exp_miso, vecs[k].exp_miso2, vecs[k].exp_vld,
                     vecs[k].exp_err, vecs[k].exp_chnl);
        end

        // Channel-5 response; batt_val changes mid-frame after load
        batt = 12'h900;
        rght = 12'h777;
        do_frame("batt_chg", 16'h2000, 16, -1, 2, 12'h100,
                 16'h0900, 16'h0900, 1, 0, 3'd4);

        // Reset after bit 7: first 7 bits of rght (0777), then zeros
        do_frame("mid_rst", 16'h2800, 16, 7, -1, 12'h000,
                 16'h0600, 16'h0600, 0, 0, 3'd0);

        // First frame after reset returns channel 0
        do_frame("post_rst", 16'h2000, 16, -1, -1, 12'h000,
                 16'h0ABC, 16'h0ABC, 1, 0, 3'd4);

        check("sb drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
